ir_decode_ctrl: RTL and testbench

Parametrised instruction fetch/decode controller: the successor to the single-unit load decoder. It sits between the instruction cache and NUM_UNITS execution units. It walks the instruction pointer and decodes opcode, unit and parameter-count fields. It issues one-hot unit starts, streams parameter words onto the data bus, and stalls per unit on busy. It also supports NOP, HALT, illegal-unit detection and pointer redirect (jump).

---
 rtl/ir_decode_ctrl_pkg.sv | 34 +++
 rtl/ir_decode_ctrl_if.sv | 39 +++
 rtl/ir_field_decode.sv | 31 +++
 rtl/ir_decode_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ir_decode_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/ir_decode_ctrl_pkg.sv
// Shared definitions for the instruction fetch/decode controller:
// state encodings, opcode constants and instruction field geometry.
package ir_decode_ctrl_pkg;

   localparam int STATE_W = 3;
   localparam int PCNT_W  = 2;

   localparam int unsigned OPC_NOP = 0;

   typedef enum logic [STATE_W-1:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_FETCH  = 3'd2,
      ST_READ_P = 3'd3,
      ST_HOLD   = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   // HALT is the all-ones opcode for whatever opcode width is in use
   function automatic int unsigned opc_halt(input int ow);
      return (32'd1 << ow) - 32'd1;
   endfunction

   // Unit id width; at least one bit even for a single-unit build
   function automatic int uid_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Parameter-count field sits directly below the opcode field
   function automatic int pcnt_msb(input int dw, input int ow);
      return dw - ow - 1;
   endfunction

endpackage

// File: rtl/ir_decode_ctrl_if.sv
// Cache / execution-unit side bundle of the decode controller.
// master = the controller, slave = the cache and execution units.
interface ir_decode_ctrl_if
   import ir_decode_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = 16,
   parameter int IR_ADDR_WIDTH = 10,
   parameter int OPC_WIDTH     = 4,
   parameter int NUM_UNITS     = 4
);

   logic                     i_cash_init_done;
   logic [DATA_WIDTH-1:0]    i_data;
   logic [NUM_UNITS-1:0]     i_unit_busy;
   logic                     i_jump_valid;
   logic [IR_ADDR_WIDTH-1:0] i_jump_addr;

   logic [IR_ADDR_WIDTH-1:0] o_irp;
   logic [DATA_WIDTH-1:0]    o_data_bus;
   logic                     o_data_valid;
   logic [PCNT_W-1:0]        o_param_idx;
   logic [NUM_UNITS-1:0]     o_unit_start;
   logic [OPC_WIDTH-1:0]     o_opcode;
   logic                     o_illegal;
   logic [STATE_W-1:0]       o_state;

   modport master (
      input  i_cash_init_done, i_data, i_unit_busy, i_jump_valid, i_jump_addr,
      output o_irp, o_data_bus, o_data_valid, o_param_idx, o_unit_start,
             o_opcode, o_illegal, o_state
   );

   modport slave (
      output i_cash_init_done, i_data, i_unit_busy, i_jump_valid, i_jump_addr,
      input  o_irp, o_data_bus, o_data_valid, o_param_idx, o_unit_start,
             o_opcode, o_illegal, o_state
   );

endinterface

// File: rtl/ir_field_decode.sv
// Combinational instruction word splitter: opcode, parameter count,
// unit id and the NOP / HALT / illegal-unit classifications.
module ir_field_decode
   import ir_decode_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int OPC_WIDTH  = 4,
   parameter int NUM_UNITS  = 4,
   parameter int UID_W      = uid_width(NUM_UNITS)
) (
   input  logic [DATA_WIDTH-1:0] word_i,
   output logic [OPC_WIDTH-1:0]  opcode_o,
   output logic [PCNT_W-1:0]     pcount_o,
   output logic [UID_W-1:0]      uid_o,
   output logic                  is_nop_o,
   output logic                  is_halt_o,
   output logic                  is_illegal_o
);

   // bits between the count field and the unit id are reserved
   logic unused_word;

   assign opcode_o     = word_i[DATA_WIDTH-1 -: OPC_WIDTH];
   assign pcount_o     = word_i[pcnt_msb(DATA_WIDTH, OPC_WIDTH) -: PCNT_W];
   assign uid_o        = word_i[UID_W-1:0];
   assign is_nop_o     = (32'(opcode_o) == OPC_NOP);
   assign is_halt_o    = (32'(opcode_o) == opc_halt(OPC_WIDTH));
   assign is_illegal_o = (32'(uid_o) >= 32'(NUM_UNITS));
   assign unused_word  = ^word_i;

endmodule

// File: rtl/ir_decode_ctrl.sv
// Instruction fetch/decode controller: walks the instruction pointer,
// issues one-hot unit starts, streams parameter words and stalls on busy.
module ir_decode_ctrl
   import ir_decode_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = 16,
   parameter int IR_ADDR_WIDTH = 10,
   parameter int OPC_WIDTH     = 4,
   parameter int NUM_UNITS     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   ir_decode_ctrl_if.master bus
);

   localparam int UID_W = uid_width(NUM_UNITS);

   state_t                   state_q, state_d;
   logic [IR_ADDR_WIDTH-1:0] irp_q, irp_d;
   logic [DATA_WIDTH-1:0]    data_bus_q, data_bus_d;
   logic                     data_valid_q, data_valid_d;
   logic [PCNT_W-1:0]        param_idx_q, param_idx_d;
   logic [NUM_UNITS-1:0]     unit_start_q, unit_start_d;
   logic [OPC_WIDTH-1:0]     opcode_q, opcode_d;
   logic                     illegal_q, illegal_d;
   logic [PCNT_W-1:0]        cnt_q, cnt_d;
   logic [PCNT_W-1:0]        idx_q, idx_d;
   logic                     pend_q, pend_d;
   logic [IR_ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
   logic [UID_W-1:0]         hold_uid_q, hold_uid_d;

   logic [OPC_WIDTH-1:0]     dec_opc;
   logic [PCNT_W-1:0]        dec_pcnt;
   logic [UID_W-1:0]         dec_uid;
   logic                     dec_nop, dec_halt, dec_illegal;
   logic                     tgt_busy, hold_busy;
   logic [NUM_UNITS-1:0]     start_oh;

   ir_field_decode #(
      .DATA_WIDTH (DATA_WIDTH),
      .OPC_WIDTH  (OPC_WIDTH),
      .NUM_UNITS  (NUM_UNITS),
      .UID_W      (UID_W)
   ) u_dec (
      .word_i       (bus.i_data),
      .opcode_o     (dec_opc),
      .pcount_o     (dec_pcnt),
      .uid_o        (dec_uid),
      .is_nop_o     (dec_nop),
      .is_halt_o    (dec_halt),
      .is_illegal_o (dec_illegal)
   );

   // Per-unit selection by loop so an out-of-range id never indexes past the vector;
   // the start shadow (unit_start_q) covers the unit's one-cycle busy-rise latency
   always_comb begin
      tgt_busy  = 1'b0;
      hold_busy = 1'b0;
      start_oh  = '0;
      for (int unsigned u = 0; u < NUM_UNITS; u++) begin
         if (dec_uid == UID_W'(u)) begin
            tgt_busy    = bus.i_unit_busy[u] | unit_start_q[u];
            start_oh[u] = 1'b1;
         end
         if (hold_uid_q == UID_W'(u)) begin
            hold_busy = bus.i_unit_busy[u];
         end
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d      = state_q;
      irp_d        = irp_q;
      data_bus_d   = data_bus_q;
      data_valid_d = 1'b0;
      param_idx_d  = param_idx_q;
      unit_start_d = '0;
      opcode_d     = opcode_q;
      illegal_d    = illegal_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      pend_d       = pend_q;
      pend_addr_d  = pend_addr_q;
      hold_uid_d   = hold_uid_q;
      unique case (state_q)
         ST_RESET: if (bus.i_cash_init_done) state_d = ST_INIT;
         ST_INIT:  if (bus.i_unit_busy == '0) state_d = ST_FETCH;
         ST_FETCH: begin
            if (bus.i_jump_valid) begin
               irp_d = bus.i_jump_addr;
            end else if (dec_nop) begin
               irp_d = irp_q + 1'b1;
            end else if (dec_halt) begin
               state_d = ST_HALT;
            end else if (dec_illegal) begin
               illegal_d = 1'b1;
               state_d   = ST_HALT;
            end else if (tgt_busy) begin
               hold_uid_d = dec_uid;
               state_d    = ST_HOLD;
            end else begin
               unit_start_d = start_oh;
               opcode_d     = dec_opc;
               irp_d        = irp_q + 1'b1;
               if (dec_pcnt != '0) begin
                  cnt_d   = dec_pcnt;
                  idx_d   = '0;
                  state_d = ST_READ_P;
               end
            end
         end
         ST_READ_P: begin
            data_bus_d   = bus.i_data;
            data_valid_d = 1'b1;
            param_idx_d  = idx_q;
            // a jump arriving on the last parameter is applied directly
            if (idx_q == cnt_q - 1'b1) begin
               state_d = ST_FETCH;
               pend_d  = 1'b0;
               if (bus.i_jump_valid)  irp_d = bus.i_jump_addr;
               else if (pend_q)       irp_d = pend_addr_q;
               else                   irp_d = irp_q + 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
               irp_d = irp_q + 1'b1;
               if (bus.i_jump_valid) begin
                  pend_d      = 1'b1;
                  pend_addr_d = bus.i_jump_addr;
               end
            end
         end
         ST_HOLD: begin
            if (bus.i_jump_valid) begin
               irp_d   = bus.i_jump_addr;
               state_d = ST_FETCH;
            end else if (!hold_busy) begin
               state_d = ST_FETCH;
            end
         end
         ST_HALT: begin
            if (bus.i_jump_valid) begin
               irp_d   = bus.i_jump_addr;
               state_d = ST_FETCH;
            end
         end
         default: state_d = ST_RESET;
      endcase
   end

   // State and output registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_RESET;
         irp_q        <= '0;
         data_bus_q   <= '0;
         data_valid_q <= 1'b0;
         param_idx_q  <= '0;
         unit_start_q <= '0;
         opcode_q     <= '0;
         illegal_q    <= 1'b0;
         cnt_q        <= '0;
         idx_q        <= '0;
         pend_q       <= 1'b0;
         pend_addr_q  <= '0;
         hold_uid_q   <= '0;
      end else begin
         state_q      <= state_d;
         irp_q        <= irp_d;
         data_bus_q   <= data_bus_d;
         data_valid_q <= data_valid_d;
         param_idx_q  <= param_idx_d;
         unit_start_q <= unit_start_d;
         opcode_q     <= opcode_d;
         illegal_q    <= illegal_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pend_q       <= pend_d;
         pend_addr_q  <= pend_addr_d;
         hold_uid_q   <= hold_uid_d;
      end
   end

   assign bus.o_irp        = irp_q;
   assign bus.o_data_bus   = data_bus_q;
   assign bus.o_data_valid = data_valid_q;
   assign bus.o_param_idx  = param_idx_q;
   assign bus.o_unit_start = unit_start_q;
   assign bus.o_opcode     = opcode_q;
   assign bus.o_illegal    = illegal_q;
   assign bus.o_state      = state_q;

endmodule

// File: tb/tb_ir_decode_ctrl.sv
// Scoreboard bench for ir_decode_ctrl: an instruction-level reference
// model predicts pointer/status per cycle and start/parameter events.
module tb_ir_decode_ctrl;

   localparam int DW = 16;
   localparam int AW = 10;
   localparam int OW = 4;
   localparam int NU = 3;
   localparam int unsigned MEMSZ = 1024;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ir_decode_ctrl_if #(.DATA_WIDTH(DW), .IR_ADDR_WIDTH(AW), .OPC_WIDTH(OW), .NUM_UNITS(NU)) bus ();

   ir_decode_ctrl #(.DATA_WIDTH(DW), .IR_ADDR_WIDTH(AW), .OPC_WIDTH(OW), .NUM_UNITS(NU)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [DW-1:0] mem [0:MEMSZ-1];
   assign bus.i_data = mem[bus.o_irp];

   typedef struct {
      logic [AW-1:0] irp;
      logic [2:0]    state;
      logic          illegal;
      logic [OW-1:0] opcode;
   } cyc_t;

   typedef struct {
      logic [NU-1:0] start;
      logic          valid;
      logic [DW-1:0] data;
      logic [1:0]    idx;
   } ev_t;

   cyc_t cq[$];
   ev_t  eq[$];
   int   tests = 0;
   int   fails = 0;
   bit   mon_en = 1'b0;

   // reference model: program position, remaining parameters, stall/halt status
   int unsigned m_pc, m_paddr, m_opc;
   int          m_left, m_pidx, m_hold, m_last;
   bit          m_halted, m_pend, m_illegal;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic [NU-1:0] b, input logic jv, input logic [AW-1:0] ja);
      ev_t           e;
      cyc_t          c;
      logic [DW-1:0] w;
      int unsigned   opc, pcn, uid;
      e.start = '0; e.valid = 1'b0; e.data = '0; e.idx = '0;
      if (m_left > 0) begin
         e.valid = 1'b1;
         e.data  = mem[m_pc];
         e.idx   = 2'(m_pidx);
         m_pidx++;
         m_left--;
         if (jv) begin m_pend = 1'b1; m_paddr = 32'(ja); end
         if (m_left == 0) begin
            m_pc   = m_pend ? m_paddr : (m_pc + 1) % MEMSZ;
            m_pend = 1'b0;
         end else begin
            m_pc = (m_pc + 1) % MEMSZ;
         end
      end else if (m_halted) begin
         if (jv) begin m_halted = 1'b0; m_pc = 32'(ja); end
      end else if (m_hold >= 0) begin
         if (jv) begin m_pc = 32'(ja); m_hold = -1; end
         else if (!b[m_hold]) m_hold = -1;
      end else begin
         w   = mem[m_pc];
         opc = 32'(w[15:12]);
         pcn = 32'(w[11:10]);
         uid = 32'(w[1:0]);
         if (jv)                                  m_pc = 32'(ja);
         else if (opc == 0)                       m_pc = (m_pc + 1) % MEMSZ;
         else if (opc == 15)                      m_halted = 1'b1;
         else if (uid >= NU) begin                m_illegal = 1'b1; m_halted = 1'b1; end
         else if (b[uid] || m_last == int'(uid))  m_hold = int'(uid);
         else begin
            e.start = NU'(1 << uid);
            m_opc   = opc;
            m_pc    = (m_pc + 1) % MEMSZ;
            if (pcn > 0) begin m_left = int'(pcn); m_pidx = 0; end
         end
      end
      m_last = -1;
      for (int u = 0; u < NU; u++) if (e.start[u]) m_last = u;
      c.irp     = AW'(m_pc);
      c.state   = m_halted ? 3'd5 : (m_left > 0) ? 3'd3 : (m_hold >= 0) ? 3'd4 : 3'd2;
      c.illegal = m_illegal;
      c.opcode  = OW'(m_opc);
      cq.push_back(c);
      if (e.start != '0 || e.valid) eq.push_back(e);
   endtask

   task automatic cyc(input logic [NU-1:0] b, input logic jv, input logic [AW-1:0] ja);
      bus.i_unit_busy  = b;
      bus.i_jump_valid = jv;
      bus.i_jump_addr  = ja;
      model_step(b, jv, ja);
      @(posedge clk);
      @(negedge clk);
   endtask

   // monitor: compares status every cycle and pops an event whenever one is presented
   initial begin
      cyc_t c;
      ev_t  e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (cq.size() == 0) begin
               chk("cycle_queue_underrun", 32'd1, 32'd0);
            end else begin
               c = cq.pop_front();
               chk("irp",     32'(bus.o_irp),     32'(c.irp));
               chk("state",   32'(bus.o_state),   32'(c.state));
               chk("illegal", 32'(bus.o_illegal), 32'(c.illegal));
               chk("opcode",  32'(bus.o_opcode),  32'(c.opcode));
            end
            if (bus.o_unit_start != '0 || bus.o_data_valid) begin
               if (eq.size() == 0) begin
                  chk("unexpected_event", 32'(bus.o_unit_start), 32'd0);
               end else begin
                  e = eq.pop_front();
                  chk("unit_start", 32'(bus.o_unit_start), 32'(e.start));
                  chk("data_valid", 32'(bus.o_data_valid), 32'(e.valid));
                  if (e.valid) begin
                     chk("data_bus",  32'(bus.o_data_bus),  32'(e.data));
                     chk("param_idx", 32'(bus.o_param_idx), 32'(e.idx));
                  end
               end
            end
         end
      end
   end

   initial begin
      logic [NU-1:0] b;
      logic          jv;
      logic [AW-1:0] ja;
      int unsigned   r, opc, uid;

      for (int unsigned a = 0; a < MEMSZ; a++) begin
         r = $urandom_range(0, 99);
         if (r < 15)      opc = 0;
         else if (r < 19) opc = 15;
         else             opc = $urandom_range(1, 14);
         uid = ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2);
         mem[a] = {OW'(opc), 2'($urandom_range(0, 3)), 8'($urandom), 2'(uid)};
      end
      mem[10'h000] = 16'h1402; mem[10'h001] = 16'hABCD; mem[10'h002] = 16'h2001;
      mem[10'h003] = 16'h2000; mem[10'h004] = 16'h3000; mem[10'h005] = 16'h1003;
      mem[10'h020] = 16'hF000; mem[10'h3FE] = 16'h3C00;

      m_pc = 0; m_paddr = 0; m_opc = 0; m_left = 0; m_pidx = 0;
      m_hold = -1; m_last = -1; m_halted = 1'b0; m_pend = 1'b0; m_illegal = 1'b0;

      rst_n = 1'b0;
      bus.i_cash_init_done = 1'b0;
      bus.i_unit_busy = '0;
      bus.i_jump_valid = 1'b0;
      bus.i_jump_addr = '0;

      // reset / init: jumps ignored, init_done seen before edge 6, dropped afterwards
      for (int e = 1; e <= 7; e++) begin
         rst_n = (e > 2);
         bus.i_cash_init_done = (e == 6);
         bus.i_jump_valid = (e == 3 || e == 7);
         bus.i_jump_addr  = (e == 3) ? 10'h155 : 10'h0AA;
         @(posedge clk);
         #1;
         chk("init_state", 32'(bus.o_state), (e <= 5) ? 32'd0 : (e == 6) ? 32'd1 : 32'd2);
         chk("init_irp",   32'(bus.o_irp), 32'd0);
         chk("init_start", 32'(bus.o_unit_start), 32'd0);
         if (e == 5) begin
            chk("init_outputs_zero",
                32'(bus.o_data_bus) | 32'(bus.o_data_valid) | 32'(bus.o_param_idx) |
                32'(bus.o_opcode) | 32'(bus.o_illegal), 32'd0);
         end
         @(negedge clk);
      end
      bus.i_cash_init_done = 1'b0;

      mon_en = 1'b1;
      // directed program: 1-param issue, busy stall, same-unit back-to-back,
      // illegal halt + jump out, HALT opcode, 3-param wrap with jump at idx 1
      for (int c = 1; c <= 22; c++) begin
         b  = (c >= 3 && c <= 5) ? 3'b010 : 3'b000;
         jv = (c == 14 || c == 16 || c == 19);
         ja = (c == 14) ? 10'h020 : (c == 16) ? 10'h3FE : 10'h100;
         cyc(b, jv, ja);
      end

      for (int c = 0; c < 3000; c++) begin
         for (int u = 0; u < NU; u++) b[u] = ($urandom_range(0, 3) == 0);
         jv = ($urandom_range(0, 15) == 0);
         ja = AW'($urandom);
         cyc(b, jv, ja);
      end
      mon_en = 1'b0;
      chk("event_queue_drained", 32'(eq.size()), 32'd0);
      chk("cycle_queue_drained", 32'(cq.size()), 32'd0);

      // mid-operation reset discards everything on the next edge
      rst_n = 1'b0;
      bus.i_jump_valid = 1'b1;
      bus.i_unit_busy = '0;
      @(posedge clk);
      #1;
      chk("rst_state",   32'(bus.o_state),      32'd0);
      chk("rst_irp",     32'(bus.o_irp),        32'd0);
      chk("rst_start",   32'(bus.o_unit_start), 32'd0);
      chk("rst_valid",   32'(bus.o_data_valid), 32'd0);
      chk("rst_data",    32'(bus.o_data_bus),   32'd0);
      chk("rst_idx",     32'(bus.o_param_idx),  32'd0);
      chk("rst_opcode",  32'(bus.o_opcode),     32'd0);
      chk("rst_illegal", 32'(bus.o_illegal),    32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
